data_sram_bridge: RTL and testbench



---
 rtl/data_sram_bridge_pkg.sv | 16 +
 rtl/data_sram_bridge.sv | 116 +++++++++++
 tb/tb_data_sram_bridge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the SRAM-style split-transaction bridges (data side now, instruction side later).
// Holds the FSM state encoding and the bus size codes.
package data_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/data_sram_bridge.sv
// MEM-stage load/store port to req/addr_ok/data_ok bus bridge.
// Stalls the pipeline until the access completes and holds load data while the pipe is frozen.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [STRB_W-1:0] mem_sel,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_except,
    input  logic              pipe_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq_from_mem,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [STRB_W-1:0] data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_t              r_state;
    logic                r_we;
    logic [STRB_W-1:0]   r_sel;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_start;
    logic                w_idle;
    logic                w_req;
    logic                w_we;
    logic [STRB_W-1:0]   w_sel;

    assign w_start = mem_en & ~mem_except;
    assign w_idle  = (r_state == ST_IDLE);

    // In IDLE the request is presented straight from the MEM stage; afterwards from the saved copy.
    assign w_req = (w_idle & w_start) | (r_state == ST_WAIT_ADDR);
    assign w_we  = w_idle ? mem_we  : r_we;
    assign w_sel = w_idle ? mem_sel : r_sel;

    assign data_req   = w_req;
    assign data_wr    = w_req & w_we;
    assign data_size  = w_idle ? mem_size  : r_size;
    assign data_addr  = w_idle ? mem_addr  : r_addr;
    assign data_wdata = w_idle ? mem_wdata : r_wdata;
    assign data_wstrb = (w_req & w_we) ? w_sel : '0;

    assign stallreq_from_mem = (w_idle & w_start)
                             | (r_state == ST_WAIT_ADDR)
                             | (r_state == ST_WAIT_DATA);
    assign mem_rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_we    <= mem_we;
                        r_sel   <= mem_sel;
                        r_size  <= mem_size;
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        if (data_addr_ok) begin
                            // A slave may accept and answer in the same cycle.
                            if (data_data_ok) begin
                                if (!mem_we) r_rdata <= data_rdata;
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_WAIT_DATA;
                            end
                        end else begin
                            r_state <= ST_WAIT_ADDR;
                        end
                    end
                end
                ST_WAIT_ADDR: begin
                    if (data_addr_ok) r_state <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (data_data_ok) begin
                        if (!r_we) r_rdata <= data_rdata;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Same instruction stays in MEM while frozen: never re-issue it.
                    if (!pipe_stall) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: directed scenarios plus randomized accesses against a
// transaction-level expectation (cycle counts derived from slave delays).
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_we, mem_except, pipe_stall;
    logic [3:0]  mem_sel;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_chk = 0;
    int n_err = 0;
    int n_hs = 0;
    int n_issued = 0;
    logic [31:0] m_rdata = 32'h0;

    always #5 clk = ~clk;

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_except(mem_except),
        .pipe_stall(pipe_stall), .mem_rdata(mem_rdata),
        .stallreq_from_mem(stallreq_from_mem),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    // Bus handshakes actually seen: must equal accesses issued (no loss, no duplicates).
    always @(negedge clk) if (!rst && data_req && data_addr_ok) n_hs++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One load/store: addr_ok after ad cycles, data_ok dd cycles after acceptance,
    // then ps extra DONE cycles with pipe_stall held.
    task automatic run_access(input logic we, input logic [3:0] sel, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int ad, input int dd, input int ps);
        int last;
        last = ad + dd + 1 + ps;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            mem_en = 1'b1; mem_except = 1'b0; mem_we = we; mem_sel = sel;
            mem_size = sz; mem_addr = addr; mem_wdata = wd;
            data_addr_ok = (c == ad);
            data_data_ok = (c == ad + dd)
                         || (c < ad && $urandom_range(3) == 0)
                         || (c > ad + dd && $urandom_range(3) == 0);
            data_rdata = (c == ad + dd) ? rd : $urandom;
            pipe_stall = (c < last);
            @(negedge clk);
            if (c <= ad) begin
                chk("req_on", 32'(data_req), 32'(1));
                chk("addr", data_addr, addr);
                chk("wr", 32'(data_wr), 32'(we));
                chk("wstrb", 32'(data_wstrb), we ? 32'(sel) : 32'(0));
                chk("size", 32'(data_size), 32'(sz));
                chk("wdata", data_wdata, wd);
            end else begin
                chk("req_off", 32'(data_req), 32'(0));
                chk("wstrb_off", 32'(data_wstrb), 32'(0));
            end
            chk("stall", 32'(stallreq_from_mem), 32'(c <= ad + dd));
            chk("rdata", mem_rdata, m_rdata);
            if (c == ad + dd && !we) m_rdata = rd;
        end
        n_issued++;
    endtask

    // Cycles with no valid access: either mem_en low or an excepting instruction.
    task automatic run_idle(input int n, input logic exc);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            mem_en = exc ? 1'b1 : 1'(($urandom_range(1)));
            mem_except = exc;
            mem_we = 1'($urandom_range(1)); mem_sel = 4'($urandom);
            mem_addr = $urandom; mem_wdata = $urandom; mem_size = 2'($urandom_range(2));
            if (!exc) mem_en = 1'b0;
            data_addr_ok = 1'($urandom_range(1));
            data_data_ok = 1'($urandom_range(1));
            data_rdata = $urandom;
            pipe_stall = 1'($urandom_range(1));
            @(negedge clk);
            chk("idle_req", 32'(data_req), 32'(0));
            chk("idle_stall", 32'(stallreq_from_mem), 32'(0));
            chk("idle_wstrb", 32'(data_wstrb), 32'(0));
            chk("idle_rdata", mem_rdata, m_rdata);
        end
    endtask

    initial begin
        rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_except = 1'b0; pipe_stall = 1'b0;
        mem_sel = 4'h0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(data_req), 32'(0));
        chk("rst_stall", 32'(stallreq_from_mem), 32'(0));
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_wstrb", 32'(data_wstrb), 32'(0));

        // Load word, immediate accept, data next cycle.
        run_access(1'b0, 4'hF, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
        // Store byte, accept delayed 3 cycles.
        run_access(1'b1, 4'b0100, 2'd0, 32'h8000_0022, 32'h00AB_0000, 32'h0, 3, 1, 0);
        // Load held in DONE by 5 cycles of pipe_stall.
        run_access(1'b0, 4'hF, 2'd2, 32'h8000_0040, 32'h0, 32'h1234_5678, 1, 2, 5);
        // Excepting instruction never reaches the bus.
        run_idle(4, 1'b1);
        // Accept and response in the same cycle.
        run_access(1'b0, 4'hF, 2'd2, 32'h8000_0050, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        // Back-to-back loads.
        run_access(1'b0, 4'hF, 2'd2, 32'h8000_0060, 32'h0, 32'h1111_1111, 0, 1, 0);
        run_access(1'b0, 4'hF, 2'd2, 32'h8000_0064, 32'h0, 32'h2222_2222, 0, 1, 0);

        // Reset while waiting for data: outstanding response is dropped.
        @(posedge clk); #1;
        mem_en = 1'b1; mem_except = 1'b0; mem_we = 1'b0; mem_addr = 32'h8000_0070;
        mem_size = 2'd2; mem_sel = 4'hF; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        pipe_stall = 1'b1;
        @(negedge clk);
        chk("rw_req", 32'(data_req), 32'(1));
        n_issued++;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rw_wait_stall", 32'(stallreq_from_mem), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0; mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        m_rdata = 32'h0;
        chk("rw_stall", 32'(stallreq_from_mem), 32'(0));
        chk("rw_req_off", 32'(data_req), 32'(0));
        chk("rw_rdata", mem_rdata, 32'h0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("rw_rdata_hold", mem_rdata, 32'h0);

        // Randomized accesses.
        for (int i = 0; i < 150; i++) begin
            logic        we;
            logic [1:0]  sz;
            int          ad, dd;
            if ($urandom_range(4) == 0) run_idle($urandom_range(1, 3), 1'($urandom_range(1)));
            we = 1'($urandom_range(1));
            sz = 2'($urandom_range(2));
            ad = $urandom_range(4);
            dd = (ad == 0) ? $urandom_range(3) : $urandom_range(1, 3);
            run_access(we, 4'($urandom_range(1, 15)), sz, $urandom, $urandom, $urandom,
                       ad, dd, $urandom_range(3));
        end
        run_idle(2, 1'b0);

        chk("handshakes", 32'(n_hs), 32'(n_issued));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
